ir_line_classifier: RTL and testbench
=====================================

Name: ir_line_classifier

Overview:
- Upstream stage of the maze/line-following controller.
- Consumes the eight time-to-discharge (ttd) values from the QTR IR array on a sample strobe.
- Runs a calibration FSM that derives a black/white threshold, then produces a registered colour vector, debounced pattern flags (on_track, left, right, lost, pos_ok) and left/right hit counts.
- Replaces the ad-hoc threshold and debounce logic in the controller with one sample-synchronous block.

Parameters:
- TTD_W, 17, width of each ttd value.
- DEB_N, 4, consecutive differing samples needed before a filtered flag changes (1 = no filtering).
- CAL_SAMPLES, 16, valid samples accumulated during calibration (>=1).

Ports:
- WF_CLK  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe; ttd_bus holds a fresh sample.
- ttd_bus  in  8*TTD_W  channel k at bits [k*TTD_W +: TTD_W].
- cal_start  in  1  pulse; begins or restarts calibration.
- cal_busy  out  1  high while in CAL.
- cal_done  out  1  one-cycle pulse when threshold is loaded.
- threshold  out  TTD_W  current threshold.
- ir_color  out  8  1 = black (ttd > threshold), bit k = channel k.
- left_sum  out  3  popcount of ir_color[7:4].
- right_sum  out  3  popcount of ir_color[3:0].
- on_track, left, right, lost, pos_ok  out  1 each  debounced flags.
- flags_valid  out  1  one-cycle pulse; flag outputs reflect a new sample.

Behaviour:
- Reset values:
  - FSM = IDLE; threshold = all ones.
  - ir_color, left_sum, right_sum = 0.
  - All flags, cal_busy, cal_done, flags_valid = 0.
  - Debounce counters = 0.
- FSM states: IDLE, CAL, RUN.
  - IDLE: samples ignored; cal_start -> CAL.
  - CAL: cal_busy = 1. Running min/max are cleared on entry (min = all ones, max = 0). Each sample_valid folds the 8-channel min/max into the running registers and increments the sample count. On the CAL_SAMPLES-th sample, the next cycle:
    - threshold = (3*min + max) >> 2, computed in TTD_W+2 bits and truncated to TTD_W;
    - cal_done pulses; state -> RUN.
  - RUN: classification active. cal_start -> CAL; threshold holds its old value until the new calibration completes.
- cal_start has priority over sample_valid in the same cycle: that sample is discarded and the count restarts at 0. cal_start during CAL restarts calibration.
- Classification pipeline (RUN only):
  - Sample at cycle t.
  - t+1: ir_color, left_sum, right_sum registered. Comparison is strict, so ttd == threshold is white.
  - t+2: filtered flags updated; flags_valid pulses.
- Raw flag definitions (from registered ir_color):
  - on_track = c[3] | c[4].
  - right = c[3:0] == 4'hF.
  - left = c[7:4] == 4'hF.
  - lost = c == 8'h00.
  - pos_ok = (c[3] | c[4]) & (c[7:5] == {c[0], c[1], c[2]}).
- Debounce, per flag, evaluated only on a classification update:
  - raw == output: counter cleared.
  - raw != output and counter == DEB_N-1: output takes raw, counter cleared.
  - Otherwise counter increments.
  - A single agreeing sample resets the count (alternating input never toggles the flag).
- Outside RUN, ir_color, the sums and the flags hold; counters hold.
- min == max: threshold equals that value, so all channels read white on that level.
- Reset asserted mid-CAL: immediate return to IDLE with reset values; the partial calibration is lost.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/CAL/RUN, 2 bits);
  - IR_CH = 8;
  - flag index constants (FLG_ON_TRACK..FLG_POS_OK).
- Sub-module flag_filter (parameter DEB_N; ports WF_CLK, rst_n, upd, raw, filt). Instantiated five times.

Test Plan:
- Reset, then any input -> threshold = 0x1FFFF, all flags 0, cal_busy 0, no flags_valid pulses while IDLE.
- cal_start, 16 samples of all channels = 100 except ch0 = 900 -> cal_done pulses one cycle after the 16th sample; threshold = (300 + 900) >> 2 = 300; state RUN.
- RUN, threshold 300, 4 samples with ch3 = ch4 = 900 (others 100) -> ir_color = 0x18; on_track and pos_ok rise with the 4th flags_valid; lost stays 0. Then 3 all-white samples followed by 1 black sample -> lost never asserts.
- Samples with ch0..3 = 900, rest 100, repeated 4 times -> right = 1, left = 0, right_sum = 4, left_sum = 0. A channel value exactly 300 reads white.
- cal_start coincident with sample_valid during CAL after 10 samples -> sample discarded; cal_done only after 16 further samples.
- rst_n low during CAL sample 8 -> immediately IDLE, threshold 0x1FFFF, cal_busy 0; no cal_done afterwards.

Source files
------------

// File: rtl/ir_line_classifier_pkg.sv
// Shared definitions for the IR line classifier.
//   - state_e : calibration/run FSM state encoding (2 bits)
//   - IR_CH   : number of IR channels in the QTR array
//   - FLG_*   : bit index of each debounced pattern flag
//   - popcount4 : ones count of a 4-bit nibble
package ir_line_classifier_pkg;

   localparam int IR_CH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CAL  = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam int FLG_ON_TRACK = 0;
   localparam int FLG_LEFT     = 1;
   localparam int FLG_RIGHT    = 2;
   localparam int FLG_LOST     = 3;
   localparam int FLG_POS_OK   = 4;
   localparam int FLG_N        = 5;

   function automatic logic [2:0] popcount4(input logic [3:0] d);
      return {2'b00, d[0]} + {2'b00, d[1]} + {2'b00, d[2]} + {2'b00, d[3]};
   endfunction

endpackage

// File: rtl/ir_line_classifier_flag_filter.sv
// Debounce filter for one pattern flag.
//   WF_CLK, rst_n : clock, async active-low reset
//   upd           : a new classification result is on raw this cycle
//   raw           : unfiltered flag
//   filt          : filtered flag; follows raw only after DEB_N consecutive
//                   disagreeing updates
// The run length is tracked as a down-counter: reloaded to DEB_N-1 whenever
// raw agrees (or the output just flipped), terminal count 0 lets raw through.
module flag_filter #(
   parameter int DEB_N = 4
) (
   input  logic WF_CLK,
   input  logic rst_n,
   input  logic upd,
   input  logic raw,
   output logic filt
);

   localparam int CW = $clog2(DEB_N + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_N - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;

   always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (upd) begin
         if (raw == filt_q) begin
            cnt_d = CNT_LOAD;
         end else if (cnt_q == '0) begin
            filt_d = raw;
            cnt_d  = CNT_LOAD;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge WF_CLK or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= CNT_LOAD;
         filt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt = filt_q;

endmodule

// File: rtl/ir_line_classifier.sv
// IR line classifier: calibrates a black/white threshold from the QTR array,
// then classifies each sample into a colour vector, left/right hit counts and
// five debounced pattern flags.
//   WF_CLK, rst_n        : clock, async active-low reset
//   sample_valid, ttd_bus: sample strobe and 8 time-to-discharge values
//   cal_start            : begin/restart calibration
//   cal_busy, cal_done   : calibrating / threshold-loaded pulse
//   threshold            : current threshold
//   ir_color, *_sum      : registered classification (sample + 1)
//   flags, flags_valid   : debounced flags and update pulse (sample + 2)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | after reset, samples ignored, waiting for cal_start
// ST_CAL  | folding CAL_SAMPLES samples into running min/max
// ST_RUN  | threshold valid, every sample is classified
module ir_line_classifier
   import ir_line_classifier_pkg::*;
#(
   parameter int TTD_W       = 17,
   parameter int DEB_N       = 4,
   parameter int CAL_SAMPLES = 16
) (
   input  logic                   WF_CLK,
   input  logic                   rst_n,
   input  logic                   sample_valid,
   input  logic [8*TTD_W-1:0]     ttd_bus,
   input  logic                   cal_start,
   output logic                   cal_busy,
   output logic                   cal_done,
   output logic [TTD_W-1:0]       threshold,
   output logic [IR_CH-1:0]       ir_color,
   output logic [2:0]             left_sum,
   output logic [2:0]             right_sum,
   output logic                   on_track,
   output logic                   left,
   output logic                   right,
   output logic                   lost,
   output logic                   pos_ok,
   output logic                   flags_valid
);

   localparam int SCW = $clog2(CAL_SAMPLES + 1);
   localparam logic [SCW-1:0] CAL_LOAD = SCW'(CAL_SAMPLES - 1);

   state_e           state_q, state_d;
   logic [TTD_W-1:0] thr_q, thr_d;
   logic [TTD_W-1:0] min_q, min_d;
   logic [TTD_W-1:0] max_q, max_d;
   logic [SCW-1:0]   cal_left_q, cal_left_d;
   logic             cal_done_q, cal_done_d;
   logic [IR_CH-1:0] color_q, color_d;
   logic [2:0]       lsum_q, lsum_d;
   logic [2:0]       rsum_q, rsum_d;
   logic             upd_q, upd_d;
   logic             fvalid_q, fvalid_d;

   logic [TTD_W-1:0] smp_min, smp_max, fold_min, fold_max;
   logic [TTD_W+1:0] thr_wide;
   logic [IR_CH-1:0] color_new;
   logic [FLG_N-1:0] raw_flags, filt_flags;

   always_comb begin
      smp_min   = '1;
      smp_max   = '0;
      color_new = '0;
      for (int k = 0; k < IR_CH; k++) begin
         if (ttd_bus[k*TTD_W +: TTD_W] < smp_min) smp_min = ttd_bus[k*TTD_W +: TTD_W];
         if (ttd_bus[k*TTD_W +: TTD_W] > smp_max) smp_max = ttd_bus[k*TTD_W +: TTD_W];
         color_new[k] = ttd_bus[k*TTD_W +: TTD_W] > thr_q;
      end
   end

   // The final calibration sample is folded in the same cycle the threshold
   // is loaded, so the threshold uses the folded values, not min_q/max_q.
   assign fold_min = (smp_min < min_q) ? smp_min : min_q;
   assign fold_max = (smp_max > max_q) ? smp_max : max_q;
   assign thr_wide = ({2'b00, fold_min} << 1) + {2'b00, fold_min} + {2'b00, fold_max};

   always_comb begin
      state_d    = state_q;
      thr_d      = thr_q;
      min_d      = min_q;
      max_d      = max_q;
      cal_left_d = cal_left_q;
      cal_done_d = 1'b0;
      color_d    = color_q;
      lsum_d     = lsum_q;
      rsum_d     = rsum_q;
      upd_d      = 1'b0;
      fvalid_d   = upd_q;
      if (cal_start) begin
         // Any sample in the same cycle is dropped; threshold keeps its value.
         state_d    = ST_CAL;
         min_d      = '1;
         max_d      = '0;
         cal_left_d = CAL_LOAD;
      end else begin
         case (state_q)
            ST_CAL: begin
               if (sample_valid) begin
                  min_d = fold_min;
                  max_d = fold_max;
                  if (cal_left_q == '0) begin
                     thr_d      = thr_wide[TTD_W+1:2];
                     cal_done_d = 1'b1;
                     state_d    = ST_RUN;
                  end else begin
                     cal_left_d = cal_left_q - 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (sample_valid) begin
                  color_d = color_new;
                  lsum_d  = popcount4(color_new[7:4]);
                  rsum_d  = popcount4(color_new[3:0]);
                  upd_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge WF_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         thr_q      <= '1;
         min_q      <= '1;
         max_q      <= '0;
         cal_left_q <= CAL_LOAD;
         cal_done_q <= 1'b0;
         color_q    <= '0;
         lsum_q     <= '0;
         rsum_q     <= '0;
         upd_q      <= 1'b0;
         fvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         thr_q      <= thr_d;
         min_q      <= min_d;
         max_q      <= max_d;
         cal_left_q <= cal_left_d;
         cal_done_q <= cal_done_d;
         color_q    <= color_d;
         lsum_q     <= lsum_d;
         rsum_q     <= rsum_d;
         upd_q      <= upd_d;
         fvalid_q   <= fvalid_d;
      end
   end

   always_comb begin
      raw_flags               = '0;
      raw_flags[FLG_ON_TRACK] = color_q[3] | color_q[4];
      raw_flags[FLG_RIGHT]    = color_q[3:0] == 4'hF;
      raw_flags[FLG_LEFT]     = color_q[7:4] == 4'hF;
      raw_flags[FLG_LOST]     = color_q == 8'h00;
      raw_flags[FLG_POS_OK]   = (color_q[3] | color_q[4]) &
                                (color_q[7:5] == {color_q[0], color_q[1], color_q[2]});
   end

   for (genvar i = 0; i < FLG_N; i++) begin : g_flt
      flag_filter #(.DEB_N(DEB_N)) u_flt (
         .WF_CLK (WF_CLK),
         .rst_n  (rst_n),
         .upd    (upd_q),
         .raw    (raw_flags[i]),
         .filt   (filt_flags[i])
      );
   end

   assign cal_busy    = (state_q == ST_CAL);
   assign cal_done    = cal_done_q;
   assign threshold   = thr_q;
   assign ir_color    = color_q;
   assign left_sum    = lsum_q;
   assign right_sum   = rsum_q;
   assign flags_valid = fvalid_q;
   assign on_track    = filt_flags[FLG_ON_TRACK];
   assign left        = filt_flags[FLG_LEFT];
   assign right       = filt_flags[FLG_RIGHT];
   assign lost        = filt_flags[FLG_LOST];
   assign pos_ok      = filt_flags[FLG_POS_OK];

endmodule

// File: tb/tb_ir_line_classifier.sv
// Self-checking bench for ir_line_classifier with a behavioural model:
// calibration as min/max over a list of samples, classification and
// debounce as plain per-sample arithmetic.
module tb_ir_line_classifier;
   localparam int TTD_W       = 17;
   localparam int DEB_N       = 4;
   localparam int CAL_SAMPLES = 16;
   localparam int ALL_ONES    = 32'h1FFFF;

   logic               WF_CLK = 1'b0;
   logic               rst_n = 1'b0;
   logic               sample_valid = 1'b0;
   logic               cal_start = 1'b0;
   logic [8*TTD_W-1:0] ttd_bus = '0;
   logic               cal_busy, cal_done, flags_valid;
   logic [TTD_W-1:0]   threshold;
   logic [7:0]         ir_color;
   logic [2:0]         left_sum, right_sum;
   logic               on_track, left, right, lost, pos_ok;

   int checks = 0;
   int errors = 0;
   int ch[8];

   // model state
   int       m_thr;
   int       m_min, m_max, m_n;
   bit       m_cal, m_run;
   bit [7:0] m_color;
   bit       m_filt[5];   // 0 on_track, 1 left, 2 right, 3 lost, 4 pos_ok
   int       m_cnt[5];

   always #5 WF_CLK = ~WF_CLK;

   ir_line_classifier #(.TTD_W(TTD_W), .DEB_N(DEB_N), .CAL_SAMPLES(CAL_SAMPLES)) dut (
      .WF_CLK       (WF_CLK),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .ttd_bus      (ttd_bus),
      .cal_start    (cal_start),
      .cal_busy     (cal_busy),
      .cal_done     (cal_done),
      .threshold    (threshold),
      .ir_color     (ir_color),
      .left_sum     (left_sum),
      .right_sum    (right_sum),
      .on_track     (on_track),
      .left         (left),
      .right        (right),
      .lost         (lost),
      .pos_ok       (pos_ok),
      .flags_valid  (flags_valid)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge WF_CLK);
      #1;
   endtask

   function automatic logic [8*TTD_W-1:0] pack_ch();
      logic [8*TTD_W-1:0] b;
      b = '0;
      for (int k = 0; k < 8; k++) b[k*TTD_W +: TTD_W] = ch[k][TTD_W-1:0];
      return b;
   endfunction

   function automatic logic [4:0] exp_flags();
      return {m_filt[0], m_filt[1], m_filt[2], m_filt[3], m_filt[4]};
   endfunction

   function automatic int ones4(input bit [3:0] n);
      return int'(n[0]) + int'(n[1]) + int'(n[2]) + int'(n[3]);
   endfunction

   task automatic model_reset();
      m_thr = ALL_ONES;
      m_cal = 1'b0;
      m_run = 1'b0;
      m_color = '0;
      for (int i = 0; i < 5; i++) begin
         m_filt[i] = 1'b0;
         m_cnt[i]  = 0;
      end
   endtask

   task automatic model_classify();
      bit raw[5];
      int lo, hi;
      for (int k = 0; k < 8; k++) m_color[k] = (ch[k] > m_thr);
      lo = int'(m_color) % 16;
      hi = int'(m_color) / 16;
      raw[0] = m_color[3] || m_color[4];
      raw[1] = (hi == 15);
      raw[2] = (lo == 15);
      raw[3] = (m_color == 0);
      raw[4] = raw[0] && (m_color[7] == m_color[0]) && (m_color[6] == m_color[1])
                      && (m_color[5] == m_color[2]);
      for (int i = 0; i < 5; i++) begin
         if (raw[i] == m_filt[i]) m_cnt[i] = 0;
         else if (m_cnt[i] == DEB_N - 1) begin
            m_filt[i] = raw[i];
            m_cnt[i]  = 0;
         end else m_cnt[i]++;
      end
   endtask

   // Drives ch[] as one sample for one cycle and advances the model.
   task automatic send();
      ttd_bus = pack_ch();
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      if (m_cal) begin
         for (int k = 0; k < 8; k++) begin
            if (ch[k] < m_min) m_min = ch[k];
            if (ch[k] > m_max) m_max = ch[k];
         end
         m_n++;
         if (m_n == CAL_SAMPLES) begin
            m_thr = ((3 * m_min + m_max) / 4) % (ALL_ONES + 1);
            m_cal = 1'b0;
            m_run = 1'b1;
         end
      end else if (m_run) begin
         model_classify();
      end
   endtask

   task automatic do_cal_start(input bit with_sample);
      cal_start = 1'b1;
      if (with_sample) begin
         for (int k = 0; k < 8; k++) ch[k] = 1;
         ttd_bus = pack_ch();
         sample_valid = 1'b1;
      end
      step();
      cal_start = 1'b0;
      sample_valid = 1'b0;
      m_cal = 1'b1;
      m_run = 1'b0;
      m_min = 32'h7FFFFFFF;
      m_max = 0;
      m_n   = 0;
   endtask

   task automatic set_pattern(input logic [7:0] p, input int blk, input int wht);
      for (int k = 0; k < 8; k++) ch[k] = p[k] ? blk : wht;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         cal_start = 1'($urandom);
         sample_valid = 1'($urandom);
         ttd_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
         step();
      end
      cal_start = 1'b0;
      sample_valid = 1'b0;
      rst_n = 1'b1;
      step();
      checks++;
      if (threshold !== m_thr[TTD_W-1:0]) begin
         errors++;
         $display("FAIL reset_threshold: got %h expected %h", threshold, m_thr);
      end
      checks++;
      if ({cal_busy, cal_done, ir_color, left_sum, right_sum, on_track, left, right, lost, pos_ok} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b color=%h flags=%b", cal_busy, cal_done,
                  ir_color, {on_track, left, right, lost, pos_ok});
      end
      for (int i = 0; i < 12; i++) begin
         for (int k = 0; k < 8; k++) ch[k] = int'($urandom_range(0, 2000));
         send();
         step();
         checks++;
         if (flags_valid !== 1'b0 || cal_busy !== 1'b0 || ir_color !== 8'h00) begin
            errors++;
            $display("FAIL idle_ignore: got fv=%b busy=%b color=%h expected 0 0 00", flags_valid, cal_busy, ir_color);
         end
      end
   endtask

   task automatic test_calibration();
      do_cal_start(1'b0);
      checks++;
      if (cal_busy !== 1'b1) begin
         errors++;
         $display("FAIL cal_busy_enter: got %b expected 1", cal_busy);
      end
      for (int i = 0; i < CAL_SAMPLES; i++) begin
         set_pattern(8'h01, 900, 100);
         send();
         checks++;
         if (cal_done !== (i == CAL_SAMPLES - 1) || cal_busy !== (i != CAL_SAMPLES - 1)) begin
            errors++;
            $display("FAIL cal_progress[%0d]: got done=%b busy=%b", i, cal_done, cal_busy);
         end
      end
      checks++;
      if (threshold !== m_thr[TTD_W-1:0] || threshold !== 17'd300) begin
         errors++;
         $display("FAIL cal_threshold: got %0d expected %0d", threshold, m_thr);
      end
      step();
      checks++;
      if (cal_done !== 1'b0) begin
         errors++;
         $display("FAIL cal_done_pulse: got %b expected 0", cal_done);
      end
   endtask

   task automatic test_on_track();
      logic [7:0] pats[8] = '{8'h18, 8'h18, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h18};
      for (int i = 0; i < 8; i++) begin
         set_pattern(pats[i], 900, 100);
         send();
         checks++;
         if (ir_color !== m_color || left_sum !== 3'(ones4(m_color[7:4]))
             || right_sum !== 3'(ones4(m_color[3:0]))) begin
            errors++;
            $display("FAIL track_color[%0d]: got %h/%0d/%0d expected %h", i, ir_color, left_sum, right_sum, m_color);
         end
         step();
         checks++;
         if (flags_valid !== 1'b1 || {on_track, left, right, lost, pos_ok} !== exp_flags() || lost !== 1'b0) begin
            errors++;
            $display("FAIL track_flags[%0d]: got fv=%b flags=%b expected fv=1 flags=%b", i, flags_valid,
                     {on_track, left, right, lost, pos_ok}, exp_flags());
         end
      end
   endtask

   task automatic test_right();
      for (int i = 0; i < 5; i++) begin
         set_pattern(8'h0F, 900, 100);
         if (i == 4) ch[2] = 300;
         send();
         checks++;
         if (ir_color !== m_color || left_sum !== 3'(ones4(m_color[7:4]))
             || right_sum !== 3'(ones4(m_color[3:0]))) begin
            errors++;
            $display("FAIL right_color[%0d]: got %h/%0d/%0d expected %h", i, ir_color, left_sum, right_sum, m_color);
         end
         step();
         checks++;
         if ({on_track, left, right, lost, pos_ok} !== exp_flags()) begin
            errors++;
            $display("FAIL right_flags[%0d]: got %b expected %b", i, {on_track, left, right, lost, pos_ok}, exp_flags());
         end
      end
   endtask

   task automatic random_sample();
      logic [7:0] pats[8] = '{8'h18, 8'h0F, 8'hF0, 8'h00, 8'h08, 8'h10, 8'hFF, 8'h81};
      logic [7:0] p;
      p = pats[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) p = 8'($urandom);
      for (int k = 0; k < 8; k++) begin
         if (p[k]) ch[k] = m_thr + 1 + int'($urandom_range(0, 1000));
         else if ($urandom_range(0, 3) == 0) ch[k] = m_thr;
         else ch[k] = int'($urandom_range(0, 32'(m_thr)));
      end
   endtask

   task automatic test_random();
      int reps;
      for (int i = 0; i < 40; i++) begin
         random_sample();
         reps = int'($urandom_range(1, 6));
         for (int r = 0; r < reps; r++) begin
            send();
            checks++;
            if (ir_color !== m_color) begin
               errors++;
               $display("FAIL rand_color: got %h expected %h", ir_color, m_color);
            end
            step();
            checks++;
            if (flags_valid !== 1'b1 || {on_track, left, right, lost, pos_ok} !== exp_flags()) begin
               errors++;
               $display("FAIL rand_flags: got fv=%b %b expected %b", flags_valid, {on_track, left, right, lost, pos_ok}, exp_flags());
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] prev;
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) random_sample();
         send();
         checks++;
         if (ir_color !== m_color) begin
            errors++;
            $display("FAIL b2b_color[%0d]: got %h expected %h", i, ir_color, m_color);
         end
         if (i > 0) begin
            checks++;
            if (flags_valid !== 1'b1 || {on_track, left, right, lost, pos_ok} !== prev) begin
               errors++;
               $display("FAIL b2b_flags[%0d]: got fv=%b %b expected %b", i, flags_valid, {on_track, left, right, lost, pos_ok}, prev);
            end
         end
         prev = exp_flags();
      end
      step();
      checks++;
      if (flags_valid !== 1'b1 || {on_track, left, right, lost, pos_ok} !== prev) begin
         errors++;
         $display("FAIL b2b_last: got fv=%b %b expected %b", flags_valid, {on_track, left, right, lost, pos_ok}, prev);
      end
   endtask

   task automatic test_cal_restart();
      int old_thr;
      logic [7:0] held;
      old_thr = m_thr;
      held = m_color;
      do_cal_start(1'b0);
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 8; k++) ch[k] = int'($urandom_range(50, 2000));
         send();
      end
      do_cal_start(1'b1);
      for (int i = 0; i < CAL_SAMPLES; i++) begin
         for (int k = 0; k < 8; k++) ch[k] = int'($urandom_range(50, 2000));
         if (i == CAL_SAMPLES - 1) begin
            checks++;
            if (threshold !== old_thr[TTD_W-1:0] || ir_color !== held) begin
               errors++;
               $display("FAIL restart_hold: got thr=%0d color=%h expected %0d %h", threshold, ir_color, old_thr, held);
            end
         end
         send();
         checks++;
         if (cal_done !== (i == CAL_SAMPLES - 1)) begin
            errors++;
            $display("FAIL restart_done[%0d]: got %b", i, cal_done);
         end
      end
      checks++;
      if (threshold !== m_thr[TTD_W-1:0]) begin
         errors++;
         $display("FAIL restart_threshold: got %0d expected %0d", threshold, m_thr);
      end
   endtask

   task automatic test_min_eq_max();
      do_cal_start(1'b0);
      for (int i = 0; i < CAL_SAMPLES; i++) begin
         set_pattern(8'h00, 500, 500);
         send();
      end
      checks++;
      if (threshold !== 17'd500 || threshold !== m_thr[TTD_W-1:0]) begin
         errors++;
         $display("FAIL flat_threshold: got %0d expected %0d", threshold, m_thr);
      end
      for (int i = 0; i < 5; i++) begin
         send();
         checks++;
         if (ir_color !== m_color) begin
            errors++;
            $display("FAIL flat_color: got %h expected %h", ir_color, m_color);
         end
         step();
         checks++;
         if ({on_track, left, right, lost, pos_ok} !== exp_flags()) begin
            errors++;
            $display("FAIL flat_flags[%0d]: got %b expected %b", i, {on_track, left, right, lost, pos_ok}, exp_flags());
         end
      end
   endtask

   task automatic test_reset_mid_cal();
      do_cal_start(1'b0);
      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < 8; k++) ch[k] = int'($urandom_range(50, 2000));
         send();
      end
      ttd_bus = pack_ch();
      sample_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (cal_busy !== 1'b0 || threshold !== m_thr[TTD_W-1:0] || ir_color !== 8'h00
          || {on_track, left, right, lost, pos_ok} !== exp_flags()) begin
         errors++;
         $display("FAIL midcal_reset: got busy=%b thr=%h color=%h flags=%b", cal_busy, threshold, ir_color,
                  {on_track, left, right, lost, pos_ok});
      end
      sample_valid = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < 8; k++) ch[k] = int'($urandom_range(50, 2000));
         send();
         checks++;
         if (cal_done !== 1'b0 || cal_busy !== 1'b0 || flags_valid !== 1'b0) begin
            errors++;
            $display("FAIL midcal_after[%0d]: got done=%b busy=%b fv=%b expected 0 0 0", i, cal_done, cal_busy, flags_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_calibration();
      test_on_track();
      test_right();
      test_random();
      test_back_to_back();
      test_cal_restart();
      test_min_eq_max();
      test_reset_mid_cal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
